// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller (dmem_ctrl / dmem_align).
// Data words use big-endian bit numbering [0:31]: bit 0 is the MSB, byte lane 0 is bits [0:7].
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  localparam int WORD_W  = 32;
  localparam int HALF_W  = 16;
  localparam int BYTE_W  = 8;
  // Right-justified lane positions inside a [0:31] word.
  localparam int HALF_RJ = WORD_W - HALF_W;
  localparam int BYTE_RJ = WORD_W - BYTE_W;

  // The byte flag wins when both sub-word flags are set.
  function automatic size_t decode_size(input logic is_byte, input logic is_half);
    if (is_byte)      return SZ_BYTE;
    else if (is_half) return SZ_HALF;
    else              return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) || ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: sub-word load extraction with optional sign extension, and
// the lane merge used by read-modify-write stores.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [0:WORD_W-1] rdata,
  input  logic [0:WORD_W-1] store_data,
  input  size_t             size,
  input  logic [1:0]        offset,
  input  logic              sext,
  output logic [0:WORD_W-1] load_data,
  output logic [0:WORD_W-1] merged_data
);

  logic [4:0]        byte_pos;
  logic [4:0]        half_pos;
  logic [0:BYTE_W-1] byte_lane;
  logic [0:HALF_W-1] half_lane;

  // Halves only look at the upper offset bit, so an odd half address falls back to its aligned half.
  assign byte_pos  = {offset, 3'b000};
  assign half_pos  = {offset[1], 4'b0000};
  assign byte_lane = rdata[byte_pos +: BYTE_W];
  assign half_lane = rdata[half_pos +: HALF_W];

  always_comb begin
    load_data   = rdata;
    merged_data = store_data;
    case (size)
      SZ_BYTE: begin
        load_data   = {{(WORD_W-BYTE_W){sext & byte_lane[0]}}, byte_lane};
        merged_data = rdata;
        merged_data[byte_pos +: BYTE_W] = store_data[BYTE_RJ +: BYTE_W];
      end
      SZ_HALF: begin
        load_data   = {{(WORD_W-HALF_W){sext & half_lane[0]}}, half_lane};
        merged_data = rdata;
        merged_data[half_pos +: HALF_W] = store_data[HALF_RJ +: HALF_W];
      end
      default: begin
        load_data   = rdata;
        merged_data = store_data;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the memory stage and a word-wide ack-handshaked SRAM.
// Optional MISALIGN_TRAP_EN adds misalign_fault and traps misaligned half/word accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [0:31]       addr_from_stage,
  input  logic [0:31]       data_from_stage,
  input  logic              write_enable,
  input  logic              byte_access,
  input  logic              half_word,
  input  logic              sign_extend,
  output logic              stall,
  output logic [0:31]       data_to_stage,
  output logic              data_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [0:31]       mem_wdata,
  input  logic [0:31]       mem_rdata,
  input  logic              mem_ack
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign_fault
`endif
);

  state_t      state;
  state_t      state_next;
  size_t       in_size;
  size_t       req_size;
  logic [1:0]  in_offset;
  logic [1:0]  req_offset;
  logic        req_we;
  logic        req_sext;
  logic [0:31] req_wdata;
  logic        trap;
  logic [0:31] load_data;
  logic [0:31] merged_data;
  logic        unused_addr_bits;

  assign in_size          = decode_size(byte_access, half_word);
  assign in_offset        = addr_from_stage[30:31];
  assign unused_addr_bits = ^addr_from_stage[0 +: 30-ADDR_W];
  assign stall            = req_valid && (state != DONE);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(in_size, in_offset);
`else
  assign trap = 1'b0;
`endif

  dmem_align u_align (
    .rdata       (mem_rdata),
    .store_data  (req_wdata),
    .size        (req_size),
    .offset      (req_offset),
    .sext        (req_sext),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Word stores skip the read; every other access reads first.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (trap)                                        state_next = DONE;
          else if (write_enable && (in_size == SZ_WORD))   state_next = WR;
          else                                             state_next = RD;
        end
      end
      RD:      if (mem_ack) state_next = req_we ? WR : DONE;
      WR:      if (mem_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SRAM-side outputs are registered from the next state so they hold steady while waiting for ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      data_to_stage <= '0;
      data_valid    <= 1'b0;
      req_size      <= SZ_WORD;
      req_offset    <= 2'b00;
      req_we        <= 1'b0;
      req_sext      <= 1'b0;
      req_wdata     <= '0;
    end else begin
      mem_req    <= (state_next == RD) || (state_next == WR);
      mem_we     <= (state_next == WR);
      data_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_size   <= in_size;
            req_offset <= in_offset;
            req_we     <= write_enable;
            req_sext   <= sign_extend;
            req_wdata  <= data_from_stage;
            mem_addr   <= addr_from_stage[30-ADDR_W +: ADDR_W];
            mem_wdata  <= data_from_stage;
            if (trap) data_to_stage <= '0;
          end
        end
        RD: begin
          if (mem_ack) begin
            if (req_we) mem_wdata     <= merged_data;
            else        data_to_stage <= load_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  // A trapped request goes straight to DONE, so the fault flag lines up with data_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_fault <= 1'b0;
    else        misalign_fault <= (state == IDLE) && req_valid && trap;
  end
`endif

endmodule
